// File: rtl/mpsoc_ahb3_spram_arbiter.sv
// Two-master AHB3 arbiter in front of a single-port RAM slave.
// Round-robin grant that is held for bursts and locked sequences; grant and data-phase state change only on HREADYOUT.
module mpsoc_ahb3_spram_arbiter #(
  parameter int PLEN = 64,
  parameter int XLEN = 64
) (
  input  logic            HCLK,
  input  logic            HRESETn,

  input  logic            m0_HSEL,
  input  logic [PLEN-1:0] m0_HADDR,
  input  logic [XLEN-1:0] m0_HWDATA,
  input  logic            m0_HWRITE,
  input  logic [2:0]      m0_HSIZE,
  input  logic [2:0]      m0_HBURST,
  input  logic [3:0]      m0_HPROT,
  input  logic [1:0]      m0_HTRANS,
  input  logic            m0_HMASTLOCK,
  output logic [XLEN-1:0] m0_HRDATA,
  output logic            m0_HREADY,
  output logic            m0_HRESP,

  input  logic            m1_HSEL,
  input  logic [PLEN-1:0] m1_HADDR,
  input  logic [XLEN-1:0] m1_HWDATA,
  input  logic            m1_HWRITE,
  input  logic [2:0]      m1_HSIZE,
  input  logic [2:0]      m1_HBURST,
  input  logic [3:0]      m1_HPROT,
  input  logic [1:0]      m1_HTRANS,
  input  logic            m1_HMASTLOCK,
  output logic [XLEN-1:0] m1_HRDATA,
  output logic            m1_HREADY,
  output logic            m1_HRESP,

  output logic            s_HSEL,
  output logic [PLEN-1:0] s_HADDR,
  output logic [XLEN-1:0] s_HWDATA,
  output logic            s_HWRITE,
  output logic [2:0]      s_HSIZE,
  output logic [2:0]      s_HBURST,
  output logic [3:0]      s_HPROT,
  output logic [1:0]      s_HTRANS,
  output logic            s_HMASTLOCK,
  output logic            s_HREADY,
  input  logic [XLEN-1:0] s_HRDATA,
  input  logic            s_HREADYOUT,
  input  logic            s_HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  logic gnt;
  logic last;
  logic dph;
  logic dvld;

  logic req0;
  logic req1;
  logic req_gnt;
  logic last_nxt;
  logic hold;
  logic own_sel;

  assign req0    = m0_HSEL & m0_HTRANS[1];
  assign req1    = m1_HSEL & m1_HTRANS[1];
  assign req_gnt = gnt ? req1 : req0;

  assign own_sel     = gnt ? m1_HSEL : m0_HSEL;
  assign s_HSEL      = own_sel;
  assign s_HTRANS    = own_sel ? (gnt ? m1_HTRANS : m0_HTRANS) : HTRANS_IDLE;
  assign s_HADDR     = gnt ? m1_HADDR     : m0_HADDR;
  assign s_HWRITE    = gnt ? m1_HWRITE    : m0_HWRITE;
  assign s_HSIZE     = gnt ? m1_HSIZE     : m0_HSIZE;
  assign s_HBURST    = gnt ? m1_HBURST    : m0_HBURST;
  assign s_HPROT     = gnt ? m1_HPROT     : m0_HPROT;
  assign s_HMASTLOCK = gnt ? m1_HMASTLOCK : m0_HMASTLOCK;
  assign s_HWDATA    = dph ? m1_HWDATA    : m0_HWDATA;
  assign s_HREADY    = s_HREADYOUT;

  assign m0_HRDATA = s_HRDATA;
  assign m1_HRDATA = s_HRDATA;
  assign m0_HRESP  = dvld & ~dph & s_HRESP;
  assign m1_HRESP  = dvld &  dph & s_HRESP;

  // A master that neither owns the address bus nor a data phase is stalled only while it requests.
  assign m0_HREADY = (~gnt | (dvld & ~dph)) ? s_HREADYOUT : ~req0;
  assign m1_HREADY = ( gnt | (dvld &  dph)) ? s_HREADYOUT : ~req1;

  assign hold = (s_HMASTLOCK & (s_HTRANS != HTRANS_IDLE))
              | (s_HTRANS == HTRANS_SEQ)
              | (s_HTRANS == HTRANS_BUSY)
              | ((s_HTRANS == HTRANS_NONSEQ) & (s_HBURST != HBURST_SINGLE));

  // Round-robin uses the owner just accepted this edge, so continuous contention alternates.
  assign last_nxt = req_gnt ? gnt : last;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      gnt  <= 1'b0;
      last <= 1'b1;
      dph  <= 1'b0;
      dvld <= 1'b0;
    end else if (s_HREADYOUT) begin
      dph  <= gnt;
      dvld <= req_gnt;
      last <= last_nxt;
      if (!hold) begin
        if (req0 & req1)
          gnt <= ~last_nxt;
        else if (req0)
          gnt <= 1'b0;
        else if (req1)
          gnt <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mpsoc_ahb3_spram_arbiter.md
MPSOC_AHB3_SPRAM_ARBITER -- requirements
Module: mpsoc_ahb3_spram_arbiter

Interface
REQ-001 SHALL have parameter PLEN, default 64, address width in bits.
REQ-002 SHALL have parameter XLEN, default 64, data width in bits.
REQ-003 SHALL use one clock and a synchronous, active-low reset:
- HCLK  input  1  clock
- HRESETn  input  1  synchronous active-low reset
REQ-004 SHALL provide these master-side ports, one bundle per master (prefix m0_ and m1_):
- mN_HSEL  input  1  select
- mN_HADDR  input  PLEN  address
- mN_HWDATA  input  XLEN  write data
- mN_HWRITE  input  1  write
- mN_HSIZE  input  3  size
- mN_HBURST  input  3  burst
- mN_HPROT  input  4  protection
- mN_HTRANS  input  2  transfer type
- mN_HMASTLOCK  input  1  lock
- mN_HRDATA  output  XLEN  read data
- mN_HREADY  output  1  ready to master
- mN_HRESP  output  1  response
REQ-005 SHALL provide these slave-side ports (prefix s_), connecting to the single-port AHB3 RAM:
- s_HSEL, s_HADDR, s_HWDATA, s_HWRITE, s_HSIZE, s_HBURST, s_HPROT, s_HTRANS, s_HMASTLOCK, s_HREADY  output  widths as REQ-004
- s_HRDATA  input  XLEN
- s_HREADYOUT  input  1
- s_HRESP  input  1

Function
REQ-006 SHALL define request r_i = mi_HSEL & mi_HTRANS[1] (NONSEQ or SEQ).
REQ-007 SHALL hold the following registers:
- gnt: address-phase owner, 1 bit
- last: last-granted master, 1 bit
- dph: data-phase owner, 1 bit
- dvld: data phase active, 1 bit
REQ-008 SHALL drive all s_ address/control outputs combinationally from master gnt.
REQ-009 SHALL force s_HSEL=0 and s_HTRANS=IDLE (00) when m<gnt>_HSEL=0.
REQ-010 SHALL drive s_HWDATA from master dph and s_HREADY = s_HREADYOUT.
REQ-011 SHALL broadcast s_HRDATA to both mN_HRDATA.
REQ-012 SHALL route mi_HRESP = s_HRESP when dvld & dph==i, else 0 (OKAY).
REQ-013 SHALL set mi_HREADY as follows:
- s_HREADYOUT when gnt==i or (dvld & dph==i)
- else 0 when r_i (stall the waiting master)
- else 1
REQ-014 SHALL update dph<=gnt and dvld<=r_gnt on each rising HCLK edge with s_HREADYOUT=1; both SHALL hold otherwise.
REQ-015 SHALL keep gnt ("hold") when the owner is in any of:
- HMASTLOCK=1 with HTRANS!=IDLE
- HTRANS=SEQ or BUSY
- HTRANS=NONSEQ with HBURST!=SINGLE
REQ-016 SHALL rearbitrate on a rising edge only when s_HREADYOUT=1 and the owner is not in hold:
- both request: gnt<=~last
- one requests: gnt<=that master
- none: gnt unchanged
REQ-017 SHALL set last<=gnt whenever an address phase with r_gnt=1 is accepted (s_HREADYOUT=1).
REQ-018 SHALL give a newly granted master its address phase on the cycle after the grant change (1-cycle arbitration latency, no lost transfer).
REQ-019 SHALL never change gnt, dph or dvld while s_HREADYOUT=0, including during a two-cycle ERROR response.
REQ-020 SHALL add no combinational path from s_HREADYOUT to gnt other than through registers.

Reset
REQ-021 SHALL, when HRESETn=0 at a rising HCLK edge, set gnt=0, last=1, dph=0, dvld=0; m0 SHALL win the first contention.
REQ-022 SHALL, in reset, produce s_HTRANS=IDLE (given m0 idle), both mN_HRESP=0, and mN_HREADY per REQ-013.
REQ-023 SHALL abandon any in-flight transfer on reset mid-operation; no state SHALL be retained.

Verification
REQ-024 Single master: m1 NONSEQ SINGLE write 0xA5 @0x10, m0 idle -> gnt=1 one cycle later; s_HTRANS=NONSEQ, s_HADDR=0x10; m1_HREADY=0 for exactly 1 cycle; readback returns 0xA5.
REQ-025 Contention after reset: both NONSEQ SINGLE in the same cycle -> m0 served first, m1_HREADY=0 until m0 is accepted, then m1 served; grants alternate 0,1,0,1 under continuous requests.
REQ-026 Burst hold: m0 INCR4 with m1 requesting -> all four m0 beats occur contiguously on s_; gnt switches to m1 only after m0 returns IDLE/NONSEQ SINGLE.
REQ-027 Lock: m1 HMASTLOCK=1 for 3 single transfers while m0 requests -> m0 stalled for all 3 transfers; m0 served after the lock drops.
REQ-028 Wait/error: s_HREADYOUT held 0 for 2 cycles, then an ERROR response -> gnt/dph stable throughout; HRESP=1 only to the data-phase owner.
REQ-029 Reset mid-burst: HRESETn=0 during an m1 SEQ beat -> next cycle gnt=0, dvld=0, s_HTRANS=IDLE.
